shift_fifo_param: RTL and testbench

- Parametrised shift-register FIFO: a control/occupancy counter, a serial storage chain and an output select mux in a single block.
- Widths and depths are configurable.
- Supports simultaneous push/pop, full/empty/almost_full status and sticky overflow/underflow error flags.
- Full-handling mode is selectable: drop the new word, or overwrite the oldest.
- Used as the generic small buffer between serial producers and consumers in the datapath.

---
 rtl/shift_fifo_param.sv | 119 +++++++++++
 tb/tb_shift_fifo_param.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_fifo_param.sv
// Parametrised shift-register FIFO with first-word fall-through read mux,
// occupancy counter, status flags and sticky overflow/underflow errors.
module shift_fifo_param #(
    parameter int WIDTH    = 4,
    parameter int DEPTH    = 8,
    parameter int AF_LEVEL = 6,
    parameter int OVERWRITE = 0,
    localparam int CW      = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] data_in,
    input  logic             clr_err,
    output logic [WIDTH-1:0] data_out,
    output logic [CW-1:0]    count,
    output logic             empty,
    output logic             full,
    output logic             almost_full,
    output logic             overflow,
    output logic             underflow
);

    localparam logic          W_OVERWRITE = (OVERWRITE != 0);
    localparam logic [CW-1:0] C_DEPTH     = CW'(DEPTH);
    localparam logic [CW-1:0] C_AF        = CW'(AF_LEVEL);

    logic [WIDTH-1:0] r_stage [DEPTH];
    logic [CW-1:0]    r_count;
    logic             r_overflow;
    logic             r_underflow;

    logic             w_full;
    logic             w_empty;
    logic             w_shift;
    logic             w_ovf_set;
    logic             w_unf_set;
    logic [CW-1:0]    w_count_next;
    logic [WIDTH-1:0] w_data_out;

    assign w_full  = (r_count == C_DEPTH);
    assign w_empty = (r_count == '0);

    // A push is refused only when full, not popping, and in drop mode.
    assign w_shift   = push & (~w_full | pop | W_OVERWRITE);
    assign w_ovf_set = push & ~pop & w_full;
    assign w_unf_set = pop & w_empty;

    always_comb begin
        w_count_next = r_count;
        if (push && pop) begin
            if (w_empty) begin
                w_count_next = CW'(1);
            end
        end else if (push) begin
            if (!w_full) begin
                w_count_next = r_count + CW'(1);
            end
        end else if (pop) begin
            if (!w_empty) begin
                w_count_next = r_count - CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_stage[i] <= '0;
            end
        end else if (w_shift) begin
            r_stage[0] <= data_in;
            for (int i = 1; i < DEPTH; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    // Error flags: a new error on the same edge as clr_err keeps the flag set.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_count <= w_count_next;
            if (w_ovf_set) begin
                r_overflow <= 1'b1;
            end else if (clr_err) begin
                r_overflow <= 1'b0;
            end
            if (w_unf_set) begin
                r_underflow <= 1'b1;
            end else if (clr_err) begin
                r_underflow <= 1'b0;
            end
        end
    end

    // Oldest word sits at stage[count-1]; zero when nothing is stored.
    always_comb begin
        w_data_out = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (r_count == CW'(i + 1)) begin
                w_data_out = r_stage[i];
            end
        end
    end

    assign data_out    = w_data_out;
    assign count       = r_count;
    assign empty       = w_empty;
    assign full        = w_full;
    assign almost_full = (r_count >= C_AF);
    assign overflow    = r_overflow;
    assign underflow   = r_underflow;

endmodule

// File: tb/tb_shift_fifo_param.sv
// Bench for shift_fifo_param: drop-mode and overwrite-mode instances share
// stimulus and are checked against queue-based reference models.
module tb_shift_fifo_param;

    localparam int WIDTH    = 4;
    localparam int DEPTH    = 8;
    localparam int AF_LEVEL = 6;
    localparam int CW       = $clog2(DEPTH + 1);
    localparam int VW       = WIDTH + CW + 5;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             push = 1'b0;
    logic             pop = 1'b0;
    logic             clr_err = 1'b0;
    logic [WIDTH-1:0] data_in = '0;

    logic [WIDTH-1:0] data_out0, data_out1;
    logic [CW-1:0]    count0, count1;
    logic             empty0, empty1, full0, full1, af0, af1;
    logic             ov0, ov1, un0, un1;
    logic [VW-1:0]    dut_vec0, dut_vec1;

    int tests_run = 0;
    int fails = 0;

    logic [WIDTH-1:0] q0[$];
    logic [WIDTH-1:0] q1[$];
    bit               m_ov[2];
    bit               m_un[2];

    shift_fifo_param #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AF_LEVEL(AF_LEVEL), .OVERWRITE(0)) dut0 (
        .clk(clk), .reset(rst_n), .push(push), .pop(pop), .data_in(data_in),
        .clr_err(clr_err), .data_out(data_out0), .count(count0), .empty(empty0),
        .full(full0), .almost_full(af0), .overflow(ov0), .underflow(un0)
    );

    shift_fifo_param #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AF_LEVEL(AF_LEVEL), .OVERWRITE(1)) dut1 (
        .clk(clk), .reset(rst_n), .push(push), .pop(pop), .data_in(data_in),
        .clr_err(clr_err), .data_out(data_out1), .count(count1), .empty(empty1),
        .full(full1), .almost_full(af1), .overflow(ov1), .underflow(un1)
    );

    assign dut_vec0 = {data_out0, count0, empty0, full0, af0, ov0, un0};
    assign dut_vec1 = {data_out1, count1, empty1, full1, af1, ov1, un1};

    always #5 clk = ~clk;

    // Reference model: queue front is the oldest word; instance 1 overwrites.
    task automatic model_apply(input int m, input bit p, input bit r,
                               input logic [WIDTH-1:0] d, input bit c);
        logic [WIDTH-1:0] tq[$];
        bit ov, un, is_full, is_empty;
        if (m == 0) tq = q0; else tq = q1;
        ov = m_ov[m];
        un = m_un[m];
        is_full  = (tq.size() == DEPTH);
        is_empty = (tq.size() == 0);
        if (c) begin
            ov = 1'b0;
            un = 1'b0;
        end
        if (p && r) begin
            if (is_empty) begin
                tq.push_back(d);
                un = 1'b1;
            end else begin
                void'(tq.pop_front());
                tq.push_back(d);
            end
        end else if (p) begin
            if (!is_full) begin
                tq.push_back(d);
            end else begin
                ov = 1'b1;
                if (m == 1) begin
                    void'(tq.pop_front());
                    tq.push_back(d);
                end
            end
        end else if (r) begin
            if (is_empty) un = 1'b1;
            else void'(tq.pop_front());
        end
        if (m == 0) q0 = tq; else q1 = tq;
        m_ov[m] = ov;
        m_un[m] = un;
    endtask

    function automatic logic [VW-1:0] exp_vec(input int m);
        int sz;
        logic [WIDTH-1:0] d;
        sz = (m == 0) ? q0.size() : q1.size();
        d  = '0;
        if (sz > 0) d = (m == 0) ? q0[0] : q1[0];
        return {d, CW'(sz), sz == 0, sz == DEPTH, sz >= AF_LEVEL, m_ov[m], m_un[m]};
    endfunction

    function automatic void model_reset();
        q0.delete();
        q1.delete();
        m_ov = '{1'b0, 1'b0};
        m_un = '{1'b0, 1'b0};
    endfunction

    // Drive one clock edge worth of inputs and advance both models.
    task automatic do_edge(input bit p, input bit r, input logic [WIDTH-1:0] d, input bit c);
        push = p;
        pop = r;
        data_in = d;
        clr_err = c;
        @(posedge clk);
        model_apply(0, p, r, d, c);
        model_apply(1, p, r, d, c);
        #1;
        push = 1'b0;
        pop = 1'b0;
        clr_err = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        model_reset();
        #12;
        tests_run++;
        if (dut_vec0 !== {{(WIDTH+CW){1'b0}}, 5'b10000}) begin
            fails++;
            $display("FAIL reset_drop: got %h expected %h", dut_vec0, {{(WIDTH+CW){1'b0}}, 5'b10000});
        end
        tests_run++;
        if (dut_vec1 !== {{(WIDTH+CW){1'b0}}, 5'b10000}) begin
            fails++;
            $display("FAIL reset_ovw: got %h expected %h", dut_vec1, {{(WIDTH+CW){1'b0}}, 5'b10000});
        end
        @(negedge clk);
        rst_n = 1'b1;
        #2;
    endtask

    task automatic test_fill();
        logic [WIDTH+CW+2:0] got, exp;
        for (int i = 1; i <= DEPTH; i++) begin
            do_edge(1'b1, 1'b0, WIDTH'(i), 1'b0);
            got = {data_out0, count0, af0, full0, ov0};
            exp = {WIDTH'(1), CW'(i), i >= AF_LEVEL, i == DEPTH, 1'b0};
            tests_run++;
            if (got !== exp) begin
                fails++;
                $display("FAIL fill[%0d]: got %h expected %h", i, got, exp);
            end
        end
    endtask

    task automatic test_full_push();
        do_edge(1'b1, 1'b0, WIDTH'(9), 1'b0);
        tests_run++;
        if ({data_out0, count0, ov0} !== {WIDTH'(1), CW'(8), 1'b1}) begin
            fails++;
            $display("FAIL full_drop: got data=%0d count=%0d ov=%b expected data=1 count=8 ov=1",
                     data_out0, count0, ov0);
        end
        tests_run++;
        if ({data_out1, count1, ov1} !== {WIDTH'(2), CW'(8), 1'b1}) begin
            fails++;
            $display("FAIL full_ovw: got data=%0d count=%0d ov=%b expected data=2 count=8 ov=1",
                     data_out1, count1, ov1);
        end
        for (int k = 1; k <= DEPTH; k++) begin
            tests_run++;
            if (data_out0 !== WIDTH'(k) || data_out1 !== WIDTH'(k + 1)) begin
                fails++;
                $display("FAIL drain[%0d]: got drop=%0d ovw=%0d expected drop=%0d ovw=%0d",
                         k, data_out0, data_out1, k, k + 1);
            end
            do_edge(1'b0, 1'b1, '0, 1'b0);
        end
        tests_run++;
        if ({empty0, empty1, data_out0, data_out1} !== {2'b11, {(2*WIDTH){1'b0}}}) begin
            fails++;
            $display("FAIL drained_empty: got e0=%b e1=%b d0=%0d d1=%0d expected 1 1 0 0",
                     empty0, empty1, data_out0, data_out1);
        end
    endtask

    task automatic test_back_to_back();
        do_edge(1'b0, 1'b0, '0, 1'b1);
        for (int v = 5; v <= 7; v++) do_edge(1'b1, 1'b0, WIDTH'(v), 1'b0);
        tests_run++;
        if ({data_out0, count0} !== {WIDTH'(5), CW'(3)}) begin
            fails++;
            $display("FAIL b2b_start: got data=%0d count=%0d expected data=5 count=3", data_out0, count0);
        end
        for (int k = 0; k < 3; k++) begin
            do_edge(1'b1, 1'b1, WIDTH'(8 + k), 1'b0);
            tests_run++;
            if ({data_out0, count0, ov0, un0, data_out1, count1, ov1, un1} !==
                {WIDTH'(6 + k), CW'(3), 2'b00, WIDTH'(6 + k), CW'(3), 2'b00}) begin
                fails++;
                $display("FAIL b2b[%0d]: got data=%0d/%0d count=%0d/%0d flags=%b%b/%b%b expected data=%0d count=3 flags=00",
                         k, data_out0, data_out1, count0, count1, ov0, un0, ov1, un1, 6 + k);
            end
        end
        for (int k = 0; k < 3; k++) do_edge(1'b0, 1'b1, '0, 1'b0);
    endtask

    task automatic test_underflow();
        do_edge(1'b0, 1'b1, '0, 1'b0);
        tests_run++;
        if ({un0, count0, un1, count1} !== {1'b1, CW'(0), 1'b1, CW'(0)}) begin
            fails++;
            $display("FAIL underflow_pop: got un=%b/%b count=%0d/%0d expected un=1 count=0",
                     un0, un1, count0, count1);
        end
        do_edge(1'b1, 1'b1, WIDTH'(4), 1'b0);
        tests_run++;
        if ({count0, data_out0, un0} !== {CW'(1), WIDTH'(4), 1'b1}) begin
            fails++;
            $display("FAIL empty_pushpop: got count=%0d data=%0d un=%b expected count=1 data=4 un=1",
                     count0, data_out0, un0);
        end
        do_edge(1'b0, 1'b0, '0, 1'b1);
        tests_run++;
        if (un0 !== 1'b0 || un1 !== 1'b0) begin
            fails++;
            $display("FAIL clr_err: got un=%b/%b expected un=0", un0, un1);
        end
        do_edge(1'b0, 1'b1, '0, 1'b0);
        do_edge(1'b0, 1'b1, '0, 1'b1);
        tests_run++;
        if (un0 !== 1'b1 || count0 !== CW'(0)) begin
            fails++;
            $display("FAIL clr_set_wins: got un=%b count=%0d expected un=1 count=0", un0, count0);
        end
    endtask

    task automatic test_async_reset();
        for (int v = 1; v <= 5; v++) do_edge(1'b1, 1'b0, WIDTH'(v + 10), 1'b0);
        #3;
        rst_n = 1'b0;
        model_reset();
        #1;
        tests_run++;
        if ({count0, empty0, data_out0, un0, ov0} !== {CW'(0), 1'b1, WIDTH'(0), 2'b00} ||
            {count1, empty1, data_out1} !== {CW'(0), 1'b1, WIDTH'(0)}) begin
            fails++;
            $display("FAIL async_reset: got count=%0d/%0d empty=%b/%b data=%0d/%0d expected count=0 empty=1 data=0",
                     count0, count1, empty0, empty1, data_out0, data_out1);
        end
        #2;
        rst_n = 1'b1;
        do_edge(1'b1, 1'b0, WIDTH'(10), 1'b0);
        tests_run++;
        if ({count0, data_out0} !== {CW'(1), WIDTH'(10)}) begin
            fails++;
            $display("FAIL post_reset_push: got count=%0d data=%0d expected count=1 data=10", count0, data_out0);
        end
    endtask

    task automatic test_random();
        bit p, r, c;
        logic [WIDTH-1:0] d;
        int push_pct;
        for (int n = 0; n < 600; n++) begin
            push_pct = (n % 200 < 100) ? 75 : 30;
            p = ($urandom_range(0, 99) < push_pct);
            r = ($urandom_range(0, 99) < 100 - push_pct);
            c = ($urandom_range(0, 15) == 0);
            d = WIDTH'($urandom);
            do_edge(p, r, d, c);
            tests_run++;
            if (dut_vec0 !== exp_vec(0)) begin
                fails++;
                $display("FAIL random_drop[%0d]: got %h expected %h", n, dut_vec0, exp_vec(0));
            end
            tests_run++;
            if (dut_vec1 !== exp_vec(1)) begin
                fails++;
                $display("FAIL random_ovw[%0d]: got %h expected %h", n, dut_vec1, exp_vec(1));
            end
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_full_push();
        test_back_to_back();
        test_underflow();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
